// File: rtl/readout_sequencer.sv
// Run-level controller for the qubit readout chain: parameter-load strobe, paced
// readout triggers with timeout, and a small result FIFO with valid/ready output.
module readout_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CFG_WAIT       = 4
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        start_run,
    input  logic        abort,
    input  logic [15:0] num_shots,
    input  logic [15:0] shot_period,
    input  logic        iq_valid,
    input  logic [31:0] i_val,
    input  logic [31:0] q_val,
    output logic        config_reset,
    output logic        trigger,
    output logic        shot_valid,
    input  logic        shot_ready,
    output logic [31:0] shot_i,
    output logic [31:0] shot_q,
    output logic [15:0] shot_idx,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [15:0] shots_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, CONFIG, SETTLE, ARM, WAIT_IQ, HOLDOFF, DONE} state_t;

    state_t        state, state_next;
    logic [15:0]   num_shots_q, period_q, period_cnt, timer, settle_cnt;
    logic [15:0]   mem_idx [FIFO_DEPTH];
    logic [31:0]   mem_i   [FIFO_DEPTH];
    logic [31:0]   mem_q   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, full, timeout_hit;

    assign full       = (count == CW'(FIFO_DEPTH));
    assign shot_valid = (count != '0);
    assign pop        = shot_valid & shot_ready;
    assign busy       = (state != IDLE);
    assign shot_i     = shot_valid ? mem_i[rd_ptr]   : '0;
    assign shot_q     = shot_valid ? mem_q[rd_ptr]   : '0;
    assign shot_idx   = shot_valid ? mem_idx[rd_ptr] : '0;

    always_comb begin
        state_next   = state;
        config_reset = 1'b0;
        trigger      = 1'b0;
        done         = 1'b0;
        push         = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            IDLE:    if (start_run) state_next = (num_shots == '0) ? DONE : CONFIG;
            CONFIG:  begin
                config_reset = 1'b1;
                state_next   = SETTLE;
            end
            SETTLE:  if (settle_cnt == 16'(CFG_WAIT - 1)) state_next = ARM;
            ARM:     if (!full && !abort) begin
                trigger    = 1'b1;
                state_next = WAIT_IQ;
            end
            // The error flag rises one cycle before the timer reaches its limit so
            // that the flag leads the exit to DONE by one cycle.
            WAIT_IQ: begin
                if (timer == 16'(TIMEOUT_CYCLES)) begin
                    state_next = DONE;
                end else if (iq_valid) begin
                    push       = 1'b1;
                    state_next = (shots_done + 16'd1 == num_shots_q) ? DONE : HOLDOFF;
                end else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                end
            end
            HOLDOFF: if (period_cnt <= 16'd1) state_next = ARM;
            DONE:    begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE) state_next = DONE;
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            state       <= IDLE;
            num_shots_q <= '0;
            period_q    <= '0;
            period_cnt  <= '0;
            timer       <= '0;
            settle_cnt  <= '0;
            shots_done  <= '0;
            timeout_err <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 16'd1 : '0;
            if (state == IDLE && start_run) begin
                num_shots_q <= num_shots;
                period_q    <= shot_period;
                shots_done  <= '0;
                timeout_err <= 1'b0;
            end
            // Loading period-1 makes the trigger cycle itself the first counted one.
            if (trigger) begin
                period_cnt <= (period_q == '0) ? '0 : period_q - 16'd1;
                timer      <= '0;
            end else begin
                if (period_cnt != '0) period_cnt <= period_cnt - 16'd1;
                if (state == WAIT_IQ) timer <= timer + 16'd1;
            end
            if (push) shots_done <= shots_done + 16'd1;
            if (timeout_hit) timeout_err <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk100) begin
        if (push) begin
            mem_idx[wr_ptr] <= shots_done;
            mem_i[wr_ptr]   <= i_val;
            mem_q[wr_ptr]   <= q_val;
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: responder answers triggers, monitor
// pops FIFO results against queued expectations; directed run scenarios.
module tb_readout_sequencer;

    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] i;
        logic [31:0] q;
    } shot_t;

    logic        clk100 = 1'b0;
    logic        reset, start_run, abort, iq_valid, shot_ready;
    logic [15:0] num_shots, shot_period, shot_idx, shots_done;
    logic [31:0] i_val, q_val, shot_i, shot_q;
    logic        config_reset, trigger, shot_valid, busy, done, timeout_err;

    int    cyc = 0;
    int    vectors = 0, miscompares = 0;
    int    trig_count = 0, done_count = 0, cfg_count = 0, pop_count = 0, cfg_cyc = 0;
    int    trig_cyc[$];
    shot_t exp_q[$];
    logic  resp_en = 1'b1;
    int    exp_idx = 0;

    readout_sequencer #(
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(50),
        .CFG_WAIT(4)
    ) dut (
        .clk100(clk100), .reset(reset), .start_run(start_run), .abort(abort),
        .num_shots(num_shots), .shot_period(shot_period), .iq_valid(iq_valid),
        .i_val(i_val), .q_val(q_val), .config_reset(config_reset), .trigger(trigger),
        .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_i(shot_i),
        .shot_q(shot_q), .shot_idx(shot_idx), .busy(busy), .done(done),
        .timeout_err(timeout_err), .shots_done(shots_done)
    );

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: event bookkeeping and scoreboard pops.
    always @(negedge clk100) begin : monitor
        shot_t e;
        if (reset) begin
            if (trigger) begin
                trig_count++;
                trig_cyc.push_back(cyc);
            end
            if (done) done_count++;
            if (config_reset) begin
                cfg_count++;
                cfg_cyc = cyc;
            end
            if (shot_valid && shot_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_unexpected: idx %0d popped, nothing expected", shot_idx);
                end else begin
                    e = exp_q.pop_front();
                    check_vec("shot_data", 128'({shot_idx, shot_i, shot_q}), 128'(e));
                end
            end
        end
    end

    // Responder: iq_valid 10 cycles after each trigger, expectation queued on issue.
    initial begin : responder
        int pend;
        pend = 0;
        iq_valid = 1'b0;
        i_val = '0;
        q_val = '0;
        forever begin
            @(posedge clk100);
            #1;
            iq_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && resp_en) begin
                    iq_valid = 1'b1;
                    i_val = 32'h1111_0000 | 32'(exp_idx);
                    q_val = 32'h8000_0000 | 32'(exp_idx << 4);
                    exp_q.push_back({16'(exp_idx), i_val, q_val});
                    exp_idx++;
                end
            end
            @(negedge clk100);
            if (trigger) pend = 10;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic wait_for(input int sel, input int max, output int at);
        logic hit;
        at = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk100);
            hit = (sel == 0) ? done : (sel == 1) ? trigger : timeout_err;
            if (hit) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", sel, max);
        end
    endtask

    task automatic start(input logic [15:0] n, input logic [15:0] p, output int s);
        trig_count = 0;
        trig_cyc.delete();
        done_count = 0;
        cfg_count = 0;
        pop_count = 0;
        exp_idx = 0;
        num_shots = n;
        shot_period = p;
        start_run = 1'b1;
        s = cyc;
        tick(1);
        start_run = 1'b0;
    endtask

    task automatic basic_run(input string tag);
        int s, d;
        shot_ready = 1'b1;
        start(16'd3, 16'd20, s);
        wait_for(0, 200, d);
        tick(1);
        check_int({tag, "_cfg_cycle"}, cfg_cyc, s + 1);
        check_int({tag, "_cfg_count"}, cfg_count, 1);
        check_int({tag, "_trig_count"}, trig_count, 3);
        if (trig_cyc.size() == 3) begin
            check_int({tag, "_first_trig"}, trig_cyc[0], s + 6);
            check_int({tag, "_spacing01"}, trig_cyc[1] - trig_cyc[0], 20);
            check_int({tag, "_spacing12"}, trig_cyc[2] - trig_cyc[1], 20);
            check_int({tag, "_done_cycle"}, d, trig_cyc[2] + 11);
        end
        check_int({tag, "_done_count"}, done_count, 1);
        check_int({tag, "_busy_after"}, int'(busy), 0);
        check_int({tag, "_shots_done"}, int'(shots_done), 3);
        check_int({tag, "_pops"}, pop_count, 3);
        check_int({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s, d, t, e, t2;
        reset = 1'b0;
        start_run = 1'b0;
        abort = 1'b0;
        num_shots = '0;
        shot_period = '0;
        shot_ready = 1'b1;
        tick(3);
        check_vec("reset_ctrl", 128'({config_reset, trigger, shot_valid, busy, done,
                  timeout_err, shots_done, shot_idx}), '0);
        check_vec("reset_data", 128'({shot_i, shot_q}), '0);
        reset = 1'b1;
        tick(2);

        basic_run("basic");

        // Zero shots
        start(16'd0, 16'd5, s);
        wait_for(0, 20, d);
        tick(1);
        check_int("zero_done_cycle", d, s + 1);
        check_int("zero_cfg_count", cfg_count, 0);
        check_int("zero_trig_count", trig_count, 0);
        check_int("zero_busy", int'(busy), 0);

        // Backpressure: FIFO fills, ARM stalls
        shot_ready = 1'b0;
        start(16'd6, 16'd20, s);
        tick(200);
        check_int("bp_trig_stall", trig_count, 4);
        check_int("bp_busy", int'(busy), 1);
        check_int("bp_head_valid", int'(shot_valid), 1);
        check_int("bp_head_idx", int'(shot_idx), 0);
        check_int("bp_shots_done", int'(shots_done), 4);
        shot_ready = 1'b1;
        wait_for(0, 400, d);
        tick(1);
        check_int("bp_trig_total", trig_count, 6);
        check_int("bp_pops", pop_count, 6);
        check_int("bp_sb_left", exp_q.size(), 0);
        check_int("bp_done_count", done_count, 1);

        // Timeout: no iq_valid
        resp_en = 1'b0;
        start(16'd2, 16'd20, s);
        wait_for(1, 50, t);
        wait_for(2, 100, e);
        check_int("to_err_cycle", e, t + 51);
        wait_for(0, 5, d);
        check_int("to_done_cycle", d, t + 52);
        tick(1);
        check_int("to_err_sticky", int'(timeout_err), 1);
        check_int("to_trig_count", trig_count, 1);
        check_int("to_fifo_empty", int'(shot_valid), 0);
        check_int("to_shots_done", int'(shots_done), 0);
        resp_en = 1'b1;

        // Abort in HOLDOFF after the second result
        shot_ready = 1'b0;
        start(16'd5, 16'd20, s);
        check_int("abort_err_cleared", int'(timeout_err), 0);
        wait_for(1, 50, t);
        wait_for(1, 50, t2);
        tick(12);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_for(0, 5, d);
        check_int("abort_done_cycle", d, t2 + 13);
        tick(1);
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_head_valid", int'(shot_valid), 1);
        check_int("abort_head_idx", int'(shot_idx), 0);
        check_int("abort_shots_done", int'(shots_done), 2);
        tick(30);
        check_int("abort_trig_count", trig_count, 2);
        shot_ready = 1'b1;
        tick(5);
        check_int("abort_pops", pop_count, 2);
        check_int("abort_sb_left", exp_q.size(), 0);

        // Reset during WAIT_IQ of the second shot
        shot_ready = 1'b0;
        start(16'd3, 16'd20, s);
        wait_for(1, 50, t);
        wait_for(1, 50, t2);
        tick(5);
        check_int("mr_pre_valid", int'(shot_valid), 1);
        check_int("mr_pre_shots", int'(shots_done), 1);
        resp_en = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        done_count = 0;
        tick(1);
        check_vec("mr_ctrl_zero", 128'({config_reset, trigger, shot_valid, busy, done,
                  timeout_err, shots_done, shot_idx}), '0);
        check_vec("mr_data_zero", 128'({shot_i, shot_q}), '0);
        tick(1);
        reset = 1'b1;
        tick(15);
        check_int("mr_no_done", done_count, 0);
        check_int("mr_idle", int'(busy), 0);
        resp_en = 1'b1;
        basic_run("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
